// File: rtl/clockworks_pkg.sv
// clockworks_pkg: shared definitions for the clockworks clock/reset front end.
//   CW_SLOW_DEFAULT       - default divider exponent (clk period = 2^(SLOW+1) CLK cycles)
//   CW_RST_CYCLES_DEFAULT - default number of clk rises that see resetn low
//   cw_hold_width()       - width of the reset-stretch hold counter
package clockworks_pkg;

    localparam int CW_SLOW_DEFAULT       = 24;
    localparam int CW_RST_CYCLES_DEFAULT = 4;

    // The hold counter must be able to represent RST_CYCLES itself.
    function automatic int cw_hold_width(input int rst_cycles);
        return $clog2(rst_cycles + 1);
    endfunction

endpackage

// File: rtl/clockworks_rst_stretch.sv
// clockworks_rst_stretch: saturating hold counter that stretches the core reset.
//   CLK    (in)  board clock, rising edge
//   RESET  (in)  synchronous active-high reset; clears the count and drives resetn low
//   en     (in)  count enable; the top pulses it on each clk fall event
//   resetn (out) registered active-low core reset; rises in the cycle the count
//                reaches RST_CYCLES and stays high until RESET
module clockworks_rst_stretch
    import clockworks_pkg::*;
#(
    parameter int RST_CYCLES = CW_RST_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic en,
    output logic resetn
);

    localparam int            HW       = cw_hold_width(RST_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RST_CYCLES);

    // Initial values give a working power-up reset without a RESET pulse.
    logic [HW-1:0] hold_q   = '0;
    logic [HW-1:0] hold_d;
    logic          resetn_q = 1'b0;
    logic          resetn_d;

    always_comb begin
        hold_d   = hold_q;
        resetn_d = resetn_q;
        if (RESET) begin
            hold_d   = '0;
            resetn_d = 1'b0;
        end else begin
            if (en && (hold_q != HOLD_MAX)) begin
                hold_d = hold_q + HW'(1);
            end
            // Because the count saturates, resetn stays high once released.
            resetn_d = (hold_d == HOLD_MAX);
        end
    end

    always_ff @(posedge CLK) begin
        hold_q   <= hold_d;
        resetn_q <= resetn_d;
    end

    assign resetn = resetn_q;

endmodule

// File: rtl/clockworks_div.sv
// clockworks_div: board-clock divider and stretched core reset.
//   CLK       (in)  board clock, all registers on its rising edge
//   RESET     (in)  synchronous active-high reset
//   slow_tick (out) only with CLOCKWORKS_TICK_EN: one-CLK pulse in each clk rise cycle
//   clk       (out) core clock = counter[SLOW]; equals CLK when SLOW=0
//   resetn    (out) registered active-low core reset, changes only at clk fall events
// Optional feature macro: CLOCKWORKS_TICK_EN adds the slow_tick output.
module clockworks_div
    import clockworks_pkg::*;
#(
    parameter int SLOW       = CW_SLOW_DEFAULT,
    parameter int RST_CYCLES = CW_RST_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
`ifdef CLOCKWORKS_TICK_EN
    output logic slow_tick,
`endif
    output logic clk,
    output logic resetn
);

    logic fall_en;

    generate
        if (SLOW > 0) begin : g_div
            // Counter value in the cycle just before clk goes high.
            localparam logic [SLOW:0] RISE_AT = {1'b0, {SLOW{1'b1}}};

            logic [SLOW:0] cnt_q = '0;
            logic [SLOW:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q + (SLOW+1)'(1);
                if (RESET) begin
                    cnt_d = '0;
                end
            end

            always_ff @(posedge CLK) begin
                cnt_q <= cnt_d;
            end

            assign clk = cnt_q[SLOW];
            // All-ones means the counter wraps to 0 at this edge: clk falls.
            assign fall_en = &cnt_q;
`ifdef CLOCKWORKS_TICK_EN
            assign slow_tick = ~RESET & (cnt_q == RISE_AT);
`endif
        end else begin : g_bypass
            assign clk     = CLK;
            assign fall_en = 1'b1;
`ifdef CLOCKWORKS_TICK_EN
            assign slow_tick = ~RESET;
`endif
        end
    endgenerate

    clockworks_rst_stretch #(
        .RST_CYCLES(RST_CYCLES)
    ) u_rst_stretch (
        .CLK   (CLK),
        .RESET (RESET),
        .en    (fall_en),
        .resetn(resetn)
    );

endmodule

// File: tb/tb_clockworks_div.sv
// tb_clockworks_div: checks a divided instance (SLOW=2, RST_CYCLES=4) and a
// bypass instance (SLOW=0, RST_CYCLES=2) sharing one board clock.
module tb_clockworks_div;

    localparam int A_SLOW   = 2;
    localparam int A_RST    = 4;
    localparam int A_PERIOD = 1 << (A_SLOW + 1);
    localparam int B_RST    = 2;

    // ---------------- clock / reset ----------------
    logic CLK   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 CLK = ~CLK;

    logic clk_a, resetn_a, clk_b, resetn_b;
`ifdef CLOCKWORKS_TICK_EN
    logic tick_a, tick_b;
`endif

    clockworks_div #(.SLOW(A_SLOW), .RST_CYCLES(A_RST)) u_dut_a (
        .CLK      (CLK),
        .RESET    (rst_a),
`ifdef CLOCKWORKS_TICK_EN
        .slow_tick(tick_a),
`endif
        .clk      (clk_a),
        .resetn   (resetn_a)
    );

    clockworks_div #(.SLOW(0), .RST_CYCLES(B_RST)) u_dut_b (
        .CLK      (CLK),
        .RESET    (rst_b),
`ifdef CLOCKWORKS_TICK_EN
        .slow_tick(tick_b),
`endif
        .clk      (clk_b),
        .resetn   (resetn_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [0:0] exp_q[$];   // expected resetn at each upcoming clk_a rise

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: CLK edges since the last edge that sampled RESET high. Power-up
    // counters start at 0, which is the same as a reset just before time 0.
    int k_a = 0;
    int k_b = 0;

    always begin
        @(posedge CLK);
        k_a = rst_a ? 0 : ((k_a < 100000) ? k_a + 1 : k_a);
        k_b = rst_b ? 0 : ((k_b < 100000) ? k_b + 1 : k_b);
        #2;
        check("a_clk",    clk_a,    ((k_a % A_PERIOD) >= (A_PERIOD / 2)) ? 1 : 0);
        check("a_resetn", resetn_a, (k_a >= A_PERIOD * A_RST) ? 1 : 0);
        check("b_clk_hi", clk_b,    1);
        check("b_resetn", resetn_b, (k_b >= B_RST) ? 1 : 0);
`ifdef CLOCKWORKS_TICK_EN
        check("a_tick", tick_a, (!rst_a && (k_a % A_PERIOD) == (A_PERIOD / 2 - 1)) ? 1 : 0);
        check("b_tick", tick_b, rst_b ? 0 : 1);
`endif
        @(negedge CLK);
        #1;
        check("b_clk_lo", clk_b, 0);
    end

    // resetn seen by each clk_a rise, against hand-written expectations.
    always begin
        @(posedge clk_a);
        #1;
        if (exp_q.size() > 0) begin
            check("rise_resetn", resetn_a, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_stretch();
        for (int i = 0; i < A_RST; i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
    endtask

    // Edges after release until clk_a first reads high (sampled #1 after edge).
    task automatic edges_to_rise(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            n++;
            if (clk_a) break;
        end
    endtask

    task automatic phase_len(input logic level, output int n);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (clk_a !== level) break;
            n++;
        end
    endtask

    int n, hi, lo;
    logic found;

    initial begin
        // Power-up without any RESET pulse.
        push_stretch();
        repeat (45) @(negedge CLK);
        check("powerup_resetn_a", resetn_a, 1);
        check("powerup_resetn_b", resetn_b, 1);

        // RESET for 5 cycles, then release.
        rst_a = 1'b1;
        repeat (5) @(negedge CLK);
        check("rst_clk_low",    clk_a,    0);
        check("rst_resetn_low", resetn_a, 0);
        push_stretch();
        rst_a = 1'b0;
        edges_to_rise(n);
        check("first_rise_edges", n, 4);
        phase_len(1'b1, hi);
        check("high_phase", hi, 4);
        phase_len(1'b0, lo);
        check("low_phase", lo, 4);

        // One-cycle RESET while resetn=1 and clk=1.
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (resetn_a && clk_a) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_hi_hi", found, 1);
        rst_a = 1'b1;
        @(posedge CLK);
        #1;
        check("abort_clk",    clk_a,    0);
        check("abort_resetn", resetn_a, 0);
        @(negedge CLK);
        push_stretch();
        rst_a = 1'b0;
        repeat (45) @(negedge CLK);
        check("restretch_resetn", resetn_a, 1);

        // Bypass instance: resetn 2 edges after release.
        rst_b = 1'b1;
        repeat (3) @(negedge CLK);
        check("b_rst_resetn", resetn_b, 0);
        rst_b = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            n++;
            if (resetn_b) break;
        end
        check("b_release_edges", n, 2);
        repeat (4) @(negedge CLK);

        // ---------------- final report ----------------
        check("rise_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clockworks_div.md
Name: clockworks_div

Overview:
- Clock/reset front end for the SOC.
- Divides the board clock CLK by a power of two to produce a slow core clock `clk`.
- Produces a stretched, active-low core reset `resetn` that is clean with respect to `clk` edges.
- Sits between the board pins and every `clk`-domain block, e.g. the processor state machine.

Parameters:
- SLOW, default 24: divider exponent; `clk` period = 2^(SLOW+1) CLK cycles; SLOW=0 means `clk` is CLK (bypass).
- RST_CYCLES, default 4: number of `clk` rising edges on which `resetn` is guaranteed low after RESET releases; legal range 1..255.

Ports:
- CLK, input, 1: board clock; all internal registers are clocked on its rising edge.
- RESET, input, 1: reset, synchronous to CLK, active-high.
- clk, output, 1: divided core clock, driven directly from a register bit.
- resetn, output, 1: core reset, active-low, registered.
- slow_tick, output, 1: present only with CLOCKWORKS_TICK_EN (see Optional Feature).

Behaviour:
- Interface (already decided): one clock, CLK; reset RESET is synchronous and active-high.
- Divider, SLOW>0:
  - Free-running counter, SLOW+1 bits wide, increments by 1 each CLK cycle and wraps from all-ones to 0.
  - clk = counter[SLOW]; duty cycle 50%.
- clk rise event: the CLK cycle in which counter changes from 2^SLOW-1 to 2^SLOW.
- clk fall event: the CLK cycle in which counter wraps to 0.
- RESET=1 at a CLK edge (SLOW>0):
  - counter <= 0, so clk=0 (clk is held low for as long as RESET stays high).
  - hold counter <= 0.
  - resetn <= 0.
- RESET has priority over all other updates in the same cycle. Asserting RESET mid-operation aborts any count in progress; clk may be truncated on a high phase.
- Reset stretch (SLOW>0):
  - After RESET deasserts, the hold counter increments on each clk fall event until it equals RST_CYCLES, then saturates.
  - resetn <= 1 in the same CLK cycle the hold counter reaches RST_CYCLES.
  - resetn therefore changes only at clk fall events. It is stable for 2^SLOW CLK cycles before and after every clk rising edge; there is no race with clk-domain logic.
- Resulting timing: first clk rise is 2^SLOW CLK cycles after RESET release. Rising edges 1..RST_CYCLES see resetn=0; rising edge RST_CYCLES+1 is the first with resetn=1.
- Once high, resetn stays high until RESET is asserted again.
- Reset values: clk=0, resetn=0, slow_tick=0.
- SLOW=0 (bypass):
  - clk = CLK combinationally; no divider counter.
  - Hold counter increments every CLK cycle; resetn <= 1 once the count reaches RST_CYCLES.
  - RESET behaviour as above.
- Before the first RESET: resetn initialises to 0 and the counters to 0 (via initial values), so power-up reset works without a RESET pulse.

Optional Feature:
- Macro: CLOCKWORKS_TICK_EN.
- Defined:
  - Adds output port slow_tick: a one-CLK-cycle pulse in the cycle of each clk rise event.
  - Forced 0 while RESET=1.
  - With SLOW=0, slow_tick = 1 whenever RESET=0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package clockworks_pkg holds:
  - CW_SLOW_DEFAULT=24 and CW_RST_CYCLES_DEFAULT=4;
  - a function computing the hold-counter width, $clog2(RST_CYCLES+1).
- One sub-module is natural: clockworks_rst_stretch, a saturating hold counter with an enable input (the fall event) that produces resetn.
- The divider remains in the top module.

Test Plan (SLOW=2, RST_CYCLES=4 unless noted):
1. RESET high for 5 CLK cycles then low -> clk=0 and resetn=0 throughout reset; first clk rise 4 CLK cycles after release; clk period 8 CLK cycles, 4 high and 4 low.
2. Count clk rises after release -> rises 1-4 sample resetn=0, rise 5 samples resetn=1; resetn toggles exactly at a clk fall event (counter wrap).
3. RESET reasserted for 1 cycle while resetn=1 and clk=1 -> next CLK edge gives clk=0 and resetn=0; full 4-rise stretch repeats after release.
4. SLOW=0, RST_CYCLES=2 -> clk follows CLK; resetn=1 exactly 2 CLK cycles after RESET drops.
5. With CLOCKWORKS_TICK_EN, SLOW=2 -> slow_tick high for exactly 1 CLK cycle, coincident with each counter 3->4 transition; 0 during RESET.
6. No RESET pulse after power-up -> resetn=0 for the first 4 clk rises, then 1.
